// File: rtl/rd_track_pipe.sv
// Destination/result tracker for EX, MEM and WB: publishes per-stage rd for hazard checks,
// returns forwarding data, drives the regfile write port and counts stall/bubble cycles.
module rd_track_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_regwrite,
  input  logic             i_id_memread,
  input  logic [XLEN-1:0]  i_ex_result,
  input  logic [XLEN-1:0]  i_mem_rdata,
  input  logic             i_load_use,
  input  logic             i_flush,
  output logic [4:0]       o_ex_rd,
  output logic [4:0]       o_mem_rd,
  output logic [4:0]       o_wb_rd,
  output logic             o_ex_memread,
  output logic [XLEN-1:0]  o_mem_fwd_data,
  output logic [XLEN-1:0]  o_wb_fwd_data,
  output logic             o_stall_ifid,
  output logic             o_wb_we,
  output logic [4:0]       o_wb_waddr,
  output logic [XLEN-1:0]  o_wb_wdata,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_ex_valid, r_ex_regwrite, r_ex_memread;
  logic [4:0]       r_ex_rd;
  logic             r_mem_valid, r_mem_regwrite, r_mem_memread;
  logic [4:0]       r_mem_rd;
  logic [XLEN-1:0]  r_mem_data;
  logic             r_wb_valid, r_wb_regwrite;
  logic [4:0]       r_wb_rd;
  logic [XLEN-1:0]  r_wb_data;
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

  logic             w_bubble;
  logic             w_stall;
  logic             w_bubble_cnt_en;
  logic [XLEN-1:0]  w_mem_value;

  // Flush wins over load_use: the wrong-path ID is dropped upstream, so no hold.
  assign w_bubble        = i_load_use | i_flush | ~i_id_valid;
  assign w_stall         = i_load_use & ~i_flush;
  assign w_bubble_cnt_en = i_load_use | i_flush;
  assign w_mem_value     = r_mem_memread ? i_mem_rdata : r_mem_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_rd        <= '0;
      r_mem_valid    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_data     <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_stall_cnt    <= '0;
      r_bubble_cnt   <= '0;
    end else begin
      if (w_bubble) begin
        r_ex_valid    <= 1'b0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
        r_ex_rd       <= '0;
      end else begin
        r_ex_valid    <= 1'b1;
        r_ex_regwrite <= i_id_regwrite;
        r_ex_memread  <= i_id_memread;
        r_ex_rd       <= i_id_rd;
      end

      r_mem_valid    <= r_ex_valid;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memread  <= r_ex_memread;
      r_mem_rd       <= r_ex_rd;
      r_mem_data     <= i_ex_result;

      r_wb_valid    <= r_mem_valid;
      r_wb_regwrite <= r_mem_regwrite;
      r_wb_rd       <= r_mem_rd;
      r_wb_data     <= w_mem_value;

      if (w_stall && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_bubble_cnt_en && (r_bubble_cnt != CNT_MAX))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  // Invalid or non-writing stages publish rd=0 so no nonzero source can match them.
  assign o_ex_rd        = (r_ex_valid  && r_ex_regwrite)  ? r_ex_rd  : 5'd0;
  assign o_mem_rd       = (r_mem_valid && r_mem_regwrite) ? r_mem_rd : 5'd0;
  assign o_wb_rd        = (r_wb_valid  && r_wb_regwrite)  ? r_wb_rd  : 5'd0;
  assign o_ex_memread   = r_ex_valid & r_ex_memread;
  assign o_mem_fwd_data = w_mem_value;
  assign o_wb_fwd_data  = r_wb_data;
  assign o_stall_ifid   = w_stall;
  assign o_wb_we        = r_wb_valid & r_wb_regwrite & (r_wb_rd != 5'd0);
  assign o_wb_waddr     = r_wb_rd;
  assign o_wb_wdata     = r_wb_data;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_rd_track_pipe.sv
// Bench for rd_track_pipe: per-cycle input history plus a stage-age model of where each
// issued instruction must be, checked every cycle, with directed literal scenarios.
module tb_rd_track_pipe;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int N     = 4096;
  localparam int SAT   = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, id_valid, id_regwrite, id_memread, load_use, flush;
  logic [4:0]       id_rd;
  logic [XLEN-1:0]  ex_result, mem_rdata;
  logic [4:0]       ex_rd, mem_rd, wb_rd, wb_waddr;
  logic             ex_memread, stall_ifid, wb_we;
  logic [XLEN-1:0]  mem_fwd_data, wb_fwd_data, wb_wdata;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  rd_track_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rd(id_rd),
    .i_id_regwrite(id_regwrite), .i_id_memread(id_memread), .i_ex_result(ex_result),
    .i_mem_rdata(mem_rdata), .i_load_use(load_use), .i_flush(flush),
    .o_ex_rd(ex_rd), .o_mem_rd(mem_rd), .o_wb_rd(wb_rd), .o_ex_memread(ex_memread),
    .o_mem_fwd_data(mem_fwd_data), .o_wb_fwd_data(wb_fwd_data), .o_stall_ifid(stall_ifid),
    .o_wb_we(wb_we), .o_wb_waddr(wb_waddr), .o_wb_wdata(wb_wdata),
    .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt)
  );

  // Input history indexed by cycle; cycle k's inputs are sampled at rising edge k.
  bit          a_v[N], a_rw[N], a_mr[N], a_lu[N], a_fl[N], a_rst[N];
  logic [4:0]  a_rd[N];
  logic [31:0] a_exr[N], a_mrd[N];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int m_stall = 0;
  int m_bub = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit issued(input int j);
    if (j < 0) return 1'b0;
    return a_v[j] && !a_lu[j] && !a_fl[j];
  endfunction

  // Instruction issued in cycle j occupies stage s (1=EX,2=MEM,3=WB) in cycle j+s,
  // provided no reset edge hit it on the way.
  function automatic bit alive(input int j, input int s);
    if (!issued(j)) return 1'b0;
    for (int i = j; i < j + s; i++)
      if (a_rst[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic compare();
    int k;
    bit e_ex, e_mem, e_wb;
    logic [31:0] exp_d;
    k = cyc;
    e_ex  = alive(k - 1, 1);
    e_mem = alive(k - 2, 2);
    e_wb  = alive(k - 3, 3);
    chk("ex_rd", {27'd0, ex_rd}, (e_ex && a_rw[k-1]) ? {27'd0, a_rd[k-1]} : 32'd0);
    chk("ex_memread", {31'd0, ex_memread}, {31'd0, e_ex && a_mr[k-1]});
    chk("mem_rd", {27'd0, mem_rd}, (e_mem && a_rw[k-2]) ? {27'd0, a_rd[k-2]} : 32'd0);
    if (e_mem) chk("mem_fwd_data", mem_fwd_data, a_mr[k-2] ? a_mrd[k] : a_exr[k-1]);
    chk("wb_rd", {27'd0, wb_rd}, (e_wb && a_rw[k-3]) ? {27'd0, a_rd[k-3]} : 32'd0);
    chk("wb_we", {31'd0, wb_we}, {31'd0, e_wb && a_rw[k-3] && (a_rd[k-3] != 5'd0)});
    chk("wb_waddr", {27'd0, wb_waddr}, e_wb ? {27'd0, a_rd[k-3]} : 32'd0);
    if (e_wb) begin
      exp_d = a_mr[k-3] ? a_mrd[k-1] : a_exr[k-2];
      chk("wb_wdata", wb_wdata, exp_d);
      chk("wb_fwd_data", wb_fwd_data, exp_d);
    end
    if (a_rst[k-1]) begin
      chk("rst_mem_fwd", mem_fwd_data, 32'd0);
      chk("rst_wb_wdata", wb_wdata, 32'd0);
    end
    chk("stall_ifid", {31'd0, stall_ifid}, {31'd0, a_lu[k] && !a_fl[k]});
    chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
    chk("bubble_cnt", {28'd0, bubble_cnt}, m_bub);
  endtask

  task automatic step(input bit v, input logic [4:0] rd, input bit rw, input bit mr,
                      input bit lu, input bit fl, input bit r,
                      input logic [31:0] exr, input logic [31:0] mrd);
    @(negedge clk);
    id_valid = v; id_rd = rd; id_regwrite = rw; id_memread = mr;
    load_use = lu; flush = fl; rst = r; ex_result = exr; mem_rdata = mrd;
    a_v[cyc] = v; a_rd[cyc] = rd; a_rw[cyc] = rw; a_mr[cyc] = mr;
    a_lu[cyc] = lu; a_fl[cyc] = fl; a_rst[cyc] = r; a_exr[cyc] = exr; a_mrd[cyc] = mrd;
    #1;
    if (cyc >= 1) compare();
    if (r) begin
      m_stall = 0;
      m_bub = 0;
    end else begin
      if (lu && !fl && m_stall < SAT) m_stall++;
      if ((lu || fl) && m_bub < SAT) m_bub++;
    end
    cyc++;
  endtask

  task automatic idle();
    step(0, 5'd0, 0, 0, 0, 0, 0, $urandom, $urandom);
  endtask

  initial begin
    rst = 1; id_valid = 0; id_rd = 0; id_regwrite = 0; id_memread = 0;
    load_use = 0; flush = 0; ex_result = 0; mem_rdata = 0;

    step(0, 5'd0, 0, 0, 0, 0, 1, $urandom, $urandom);
    step(0, 5'd0, 0, 0, 0, 0, 1, $urandom, $urandom);
    idle();
    chk("reset_ex_rd", {27'd0, ex_rd}, 32'd0);
    chk("reset_wb_we", {31'd0, wb_we}, 32'd0);
    chk("reset_wb_wdata", wb_wdata, 32'd0);
    chk("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    // back-to-back ALU writers
    step(1, 5'd5, 1, 0, 0, 0, 0, $urandom, $urandom);
    step(1, 5'd6, 1, 0, 0, 0, 0, 32'h11, $urandom);
    chk("b2b_ex_rd5", {27'd0, ex_rd}, 32'd5);
    step(0, 5'd0, 0, 0, 0, 0, 0, 32'h22, $urandom);
    chk("b2b_mem_rd5", {27'd0, mem_rd}, 32'd5);
    chk("b2b_mem_fwd11", mem_fwd_data, 32'h11);
    chk("b2b_ex_rd6", {27'd0, ex_rd}, 32'd6);
    idle();
    chk("b2b_wb_we", {31'd0, wb_we}, 32'd1);
    chk("b2b_waddr5", {27'd0, wb_waddr}, 32'd5);
    chk("b2b_wdata11", wb_wdata, 32'h11);
    chk("b2b_mem_fwd22", mem_fwd_data, 32'h22);
    idle();
    chk("b2b_waddr6", {27'd0, wb_waddr}, 32'd6);
    chk("b2b_wdata22", wb_wdata, 32'h22);

    // load-use
    step(1, 5'd7, 1, 1, 0, 0, 0, $urandom, $urandom);
    step(1, 5'd8, 1, 0, 1, 0, 0, $urandom, $urandom);
    chk("lu_stall", {31'd0, stall_ifid}, 32'd1);
    chk("lu_ex_memread", {31'd0, ex_memread}, 32'd1);
    step(1, 5'd8, 1, 0, 0, 0, 0, $urandom, 32'hABCD);
    chk("lu_ex_bubble", {27'd0, ex_rd}, 32'd0);
    chk("lu_mem_rd", {27'd0, mem_rd}, 32'd7);
    chk("lu_mem_fwd", mem_fwd_data, 32'hABCD);
    chk("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);
    chk("lu_bubble_cnt", {28'd0, bubble_cnt}, 32'd1);
    idle();
    chk("lu_wb_wdata", wb_wdata, 32'hABCD);
    chk("lu_ex_rd8", {27'd0, ex_rd}, 32'd8);

    // flush together with load_use
    step(1, 5'd9, 1, 0, 1, 1, 0, $urandom, $urandom);
    chk("fl_no_stall", {31'd0, stall_ifid}, 32'd0);
    idle();
    chk("fl_ex_bubble", {27'd0, ex_rd}, 32'd0);
    chk("fl_bubble_cnt", {28'd0, bubble_cnt}, 32'd2);
    chk("fl_stall_cnt", {28'd0, stall_cnt}, 32'd1);

    // rd=0 writer
    step(1, 5'd0, 1, 0, 0, 0, 0, $urandom, $urandom);
    idle();
    idle();
    idle();
    chk("rd0_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rd0_wb_rd", {27'd0, wb_rd}, 32'd0);

    // reset with three instructions in flight
    step(1, 5'd10, 1, 0, 0, 0, 0, $urandom, $urandom);
    step(1, 5'd11, 1, 0, 0, 0, 0, $urandom, $urandom);
    step(1, 5'd12, 1, 0, 0, 0, 0, $urandom, $urandom);
    step(0, 5'd0, 0, 0, 0, 0, 1, $urandom, $urandom);
    chk("pre_rst_wb_waddr", {27'd0, wb_waddr}, 32'd10);
    step(1, 5'd13, 1, 0, 0, 0, 0, 32'h1313, $urandom);
    chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst_mem_rd", {27'd0, mem_rd}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_bubble_cnt", {28'd0, bubble_cnt}, 32'd0);
    step(0, 5'd0, 0, 0, 0, 0, 0, 32'h5151, $urandom);
    idle();
    chk("rst_wb_we_d6", {31'd0, wb_we}, 32'd0);
    idle();
    chk("new_wb_we", {31'd0, wb_we}, 32'd1);
    chk("new_wb_waddr", {27'd0, wb_waddr}, 32'd13);
    chk("new_wb_wdata", wb_wdata, 32'h5151);

    // saturation
    for (int i = 0; i < 20; i++) step(1, 5'd14, 1, 0, 1, 0, 0, $urandom, $urandom);
    idle();
    chk("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
    chk("sat_bubble_cnt", {28'd0, bubble_cnt}, 32'd15);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)) & (($urandom_range(0, 7) == 0) ? 5'd0 : 5'd31),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
           $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
